// File: rtl/if_fetch.sv
// Instruction-fetch stage of the 5-stage MIPS pipeline: owns the PC and drives the imem handshake.
// Define IF_FETCH_IMEM_WAIT_EN to honour i_imem_ready (WAIT/DRAIN states); otherwise memory is zero-wait.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_imem_ready,
  output logic [31:0] o_pc_incr,
  output logic [31:0] o_instr,
  output logic        o_fetch_valid,
  output logic [31:0] o_fetch_cnt
);

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nxt;
  logic [31:0] r_fetch_cnt;
  logic        w_ready;
  logic        w_fetch_valid;

`ifdef IF_FETCH_IMEM_WAIT_EN
  logic [31:0] r_pend_pc;
  logic [31:0] w_pend_pc_nxt;

  assign w_ready = i_imem_ready;
`else
  // Zero-wait memory: the ready input is intentionally left unobserved.
  logic w_unused_imem_ready;

  assign w_unused_imem_ready = i_imem_ready;
  assign w_ready             = 1'b1;
`endif

  // A word is only real when it completes in RUN/WAIT and is not being squashed by a redirect.
  assign w_fetch_valid = w_ready && (r_state == ST_RUN || r_state == ST_WAIT) && !i_redirect;

  assign o_imem_req    = (r_state != ST_BOOT);
  assign o_imem_addr   = r_pc;
  assign o_pc_incr     = r_pc + 32'd4;
  assign o_instr       = w_fetch_valid ? i_imem_rdata : 32'h0;
  assign o_fetch_valid = w_fetch_valid;
  assign o_fetch_cnt   = r_fetch_cnt;

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path can infer a latch.
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
`ifdef IF_FETCH_IMEM_WAIT_EN
    w_pend_pc_nxt = r_pend_pc;
`endif
    case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN, ST_WAIT: begin
        if (i_redirect) begin
`ifdef IF_FETCH_IMEM_WAIT_EN
          if (!w_ready) begin
            w_pend_pc_nxt = i_redirect_pc;
            w_state_nxt   = ST_DRAIN;
          end else
`endif
          begin
            w_pc_nxt    = i_redirect_pc;
            w_state_nxt = ST_RUN;
          end
        end
`ifdef IF_FETCH_IMEM_WAIT_EN
        else if (!w_ready) begin
          w_state_nxt = ST_WAIT;
        end
`endif
        else begin
          w_state_nxt = ST_RUN;
          if (!i_stall) begin
            w_pc_nxt = r_pc + 32'd4;
          end
        end
      end
`ifdef IF_FETCH_IMEM_WAIT_EN
      ST_DRAIN: begin
        // The address stays on the old PC until the abandoned fetch completes; latest target wins.
        if (i_redirect) begin
          w_pend_pc_nxt = i_redirect_pc;
        end
        if (w_ready) begin
          w_pc_nxt    = i_redirect ? i_redirect_pc : r_pend_pc;
          w_state_nxt = ST_RUN;
        end
      end
`endif
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= ST_BOOT;
      r_pc        <= RESET_PC;
      r_fetch_cnt <= 32'd0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (w_fetch_valid && !i_stall) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
    end
  end

`ifdef IF_FETCH_IMEM_WAIT_EN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pend_pc <= 32'd0;
    end else begin
      r_pend_pc <= w_pend_pc_nxt;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: vector table plus hand-written handshake sequences,
// with expected outputs queued at drive time and popped at the sampling edge.
module tb_if_fetch;

  localparam logic [31:0] RST_PC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] pc_incr;
  logic [31:0] instr;
  logic        fetch_valid;
  logic [31:0] fetch_cnt;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic [31:0] incr;
    logic [31:0] instr;
    logic        valid;
    logic [31:0] cnt;
  } out_t;

  typedef struct {
    string       name;
    logic        rst;
    logic        stl;
    logic        rdr;
    logic [31:0] rpc;
    logic        rdy;
    logic [31:0] rdata;
    out_t        exp;
  } vec_t;

  out_t  exp_q[$];
  string name_q[$];
  vec_t  vecs[19];

  if_fetch #(.RESET_PC(RST_PC)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .i_stall       (stall),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .o_imem_req    (imem_req),
    .o_imem_addr   (imem_addr),
    .i_imem_rdata  (imem_rdata),
    .i_imem_ready  (imem_ready),
    .o_pc_incr     (pc_incr),
    .o_instr       (instr),
    .o_fetch_valid (fetch_valid),
    .o_fetch_cnt   (fetch_cnt)
  );

  always #5 clk = ~clk;

  function automatic out_t ex(input logic req, input logic [31:0] addr, input logic [31:0] incr,
                              input logic [31:0] ins, input logic valid, input logic [31:0] cnt);
    out_t e;
    e.req   = req;
    e.addr  = addr;
    e.incr  = incr;
    e.instr = ins;
    e.valid = valid;
    e.cnt   = cnt;
    return e;
  endfunction

  function automatic vec_t mk(input string name, input logic rst, input logic stl, input logic rdr,
                              input logic [31:0] rpc, input logic rdy, input logic [31:0] rdata,
                              input out_t e);
    vec_t v;
    v.name  = name;
    v.rst   = rst;
    v.stl   = stl;
    v.rdr   = rdr;
    v.rpc   = rpc;
    v.rdy   = rdy;
    v.rdata = rdata;
    v.exp   = e;
    return v;
  endfunction

  task automatic check();
    out_t  e;
    out_t  a;
    string n;
    e = exp_q.pop_front();
    n = name_q.pop_front();
    a.req   = imem_req;
    a.addr  = imem_addr;
    a.incr  = pc_incr;
    a.instr = instr;
    a.valid = fetch_valid;
    a.cnt   = fetch_cnt;
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got req=%0b addr=%h incr=%h instr=%h valid=%0b cnt=%0d, want req=%0b addr=%h incr=%h instr=%h valid=%0b cnt=%0d",
               n, a.req, a.addr, a.incr, a.instr, a.valid, a.cnt,
               e.req, e.addr, e.incr, e.instr, e.valid, e.cnt);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare on the falling edge.
  task automatic step(input string name, input logic rst, input logic stl, input logic rdr,
                      input logic [31:0] rpc, input logic rdy, input logic [31:0] rdata,
                      input out_t e);
    reset       = rst;
    stall       = stl;
    redirect    = rdr;
    redirect_pc = rpc;
    imem_ready  = rdy;
    imem_rdata  = rdata;
    exp_q.push_back(e);
    name_q.push_back(name);
    @(negedge clk);
    check();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within the time limit");
    $fatal(1);
  end

  initial begin
    vecs[0]  = mk("reset_hold",    1, 0, 0, 32'h0,         1, 32'hDEAD_BEEF, ex(0, RST_PC,        32'h0040_0004, 32'h0,         0, 0));
    vecs[1]  = mk("boot_cycle",    0, 0, 0, 32'h0,         1, 32'hDEAD_BEEF, ex(0, RST_PC,        32'h0040_0004, 32'h0,         0, 0));
    vecs[2]  = mk("seq_0",         0, 0, 0, 32'h0,         1, 32'h1000_0000, ex(1, 32'h0040_0000, 32'h0040_0004, 32'h1000_0000, 1, 0));
    vecs[3]  = mk("seq_1",         0, 0, 0, 32'h0,         1, 32'h1000_0001, ex(1, 32'h0040_0004, 32'h0040_0008, 32'h1000_0001, 1, 1));
    vecs[4]  = mk("seq_2",         0, 0, 0, 32'h0,         1, 32'h1000_0002, ex(1, 32'h0040_0008, 32'h0040_000C, 32'h1000_0002, 1, 2));
    vecs[5]  = mk("seq_3",         0, 0, 0, 32'h0,         1, 32'h1000_0003, ex(1, 32'h0040_000C, 32'h0040_0010, 32'h1000_0003, 1, 3));
    vecs[6]  = mk("redir_stall",   0, 1, 1, 32'h0040_0008, 1, 32'h1000_0004, ex(1, 32'h0040_0010, 32'h0040_0014, 32'h0,         0, 4));
    vecs[7]  = mk("stall_0",       0, 1, 0, 32'h0,         1, 32'h1000_0005, ex(1, 32'h0040_0008, 32'h0040_000C, 32'h1000_0005, 1, 4));
    vecs[8]  = mk("stall_1",       0, 1, 0, 32'h0,         1, 32'h1000_0005, ex(1, 32'h0040_0008, 32'h0040_000C, 32'h1000_0005, 1, 4));
    vecs[9]  = mk("stall_2",       0, 1, 0, 32'h0,         1, 32'h1000_0005, ex(1, 32'h0040_0008, 32'h0040_000C, 32'h1000_0005, 1, 4));
    vecs[10] = mk("stall_release", 0, 0, 0, 32'h0,         1, 32'h1000_0005, ex(1, 32'h0040_0008, 32'h0040_000C, 32'h1000_0005, 1, 4));
    vecs[11] = mk("redir_run",     0, 0, 1, 32'h0040_0100, 1, 32'h1000_0006, ex(1, 32'h0040_000C, 32'h0040_0010, 32'h0,         0, 5));
    vecs[12] = mk("redir_target",  0, 0, 0, 32'h0,         1, 32'h1000_0007, ex(1, 32'h0040_0100, 32'h0040_0104, 32'h1000_0007, 1, 5));
    vecs[13] = mk("redir_top",     0, 0, 1, 32'hFFFF_FFFC, 1, 32'h1000_0008, ex(1, 32'h0040_0104, 32'h0040_0108, 32'h0,         0, 6));
    vecs[14] = mk("pc_top",        0, 0, 0, 32'h0,         1, 32'h1000_0009, ex(1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h1000_0009, 1, 6));
    vecs[15] = mk("pc_wrapped",    0, 0, 0, 32'h0,         1, 32'h1000_000A, ex(1, 32'h0000_0000, 32'h0000_0004, 32'h1000_000A, 1, 7));
    vecs[16] = mk("reset_in_run",  1, 0, 0, 32'h0,         1, 32'h1000_000B, ex(1, 32'h0000_0004, 32'h0000_0008, 32'h1000_000B, 1, 8));
    vecs[17] = mk("reboot",        0, 0, 0, 32'h0,         1, 32'h1000_000C, ex(0, RST_PC,        32'h0040_0004, 32'h0,         0, 0));
    vecs[18] = mk("refetch",       0, 0, 0, 32'h0,         1, 32'h1000_000D, ex(1, 32'h0040_0000, 32'h0040_0004, 32'h1000_000D, 1, 0));

    reset       = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    imem_ready  = 1'b1;
    imem_rdata  = 32'h0;
    @(posedge clk);
    #1;

    for (int i = 0; i < $size(vecs); i++) begin
      step(vecs[i].name, vecs[i].rst, vecs[i].stl, vecs[i].rdr, vecs[i].rpc,
           vecs[i].rdy, vecs[i].rdata, vecs[i].exp);
    end

`ifdef IF_FETCH_IMEM_WAIT_EN
    // Redirect during an outstanding fetch: address held, response dropped, then target.
    step("drain_enter",  0, 0, 1, 32'h0040_0200, 0, 32'hBAD0_0000, ex(1, 32'h0040_0004, 32'h0040_0008, 32'h0, 0, 1));
    step("drain_hold",   0, 0, 0, 32'h0,         0, 32'hBAD0_0001, ex(1, 32'h0040_0004, 32'h0040_0008, 32'h0, 0, 1));
    step("drain_drop",   0, 0, 0, 32'h0,         1, 32'hBAD0_0002, ex(1, 32'h0040_0004, 32'h0040_0008, 32'h0, 0, 1));
    step("drain_target", 0, 0, 0, 32'h0,         1, 32'hA000_0003, ex(1, 32'h0040_0200, 32'h0040_0204, 32'hA000_0003, 1, 1));
    // Plain wait states.
    step("wait_enter",   0, 0, 0, 32'h0,         0, 32'hBAD0_0004, ex(1, 32'h0040_0204, 32'h0040_0208, 32'h0, 0, 2));
    step("wait_hold",    0, 0, 0, 32'h0,         0, 32'hBAD0_0005, ex(1, 32'h0040_0204, 32'h0040_0208, 32'h0, 0, 2));
    step("wait_done",    0, 0, 0, 32'h0,         1, 32'hA000_0006, ex(1, 32'h0040_0204, 32'h0040_0208, 32'hA000_0006, 1, 2));
    // Two redirects while draining: the later target wins.
    step("drain2_enter", 0, 0, 1, 32'h0040_0300, 0, 32'hBAD0_0007, ex(1, 32'h0040_0208, 32'h0040_020C, 32'h0, 0, 3));
    step("drain2_over",  0, 0, 1, 32'h0040_0400, 0, 32'hBAD0_0008, ex(1, 32'h0040_0208, 32'h0040_020C, 32'h0, 0, 3));
    step("drain2_drop",  0, 0, 0, 32'h0,         1, 32'hBAD0_0009, ex(1, 32'h0040_0208, 32'h0040_020C, 32'h0, 0, 3));
    step("drain2_tgt",   0, 0, 0, 32'h0,         1, 32'hA000_000A, ex(1, 32'h0040_0400, 32'h0040_0404, 32'hA000_000A, 1, 3));
    // Redirect arriving together with the completing response in WAIT applies directly.
    step("wait2_enter",  0, 0, 0, 32'h0,         0, 32'hBAD0_000B, ex(1, 32'h0040_0404, 32'h0040_0408, 32'h0, 0, 4));
    step("wait2_redir",  0, 0, 1, 32'h0040_0500, 1, 32'hBAD0_000C, ex(1, 32'h0040_0404, 32'h0040_0408, 32'h0, 0, 4));
    step("wait2_target", 0, 0, 0, 32'h0,         1, 32'hA000_000D, ex(1, 32'h0040_0500, 32'h0040_0504, 32'hA000_000D, 1, 4));
    // Reset while waiting abandons the request.
    step("wait3_enter",  0, 0, 0, 32'h0,         0, 32'hBAD0_000E, ex(1, 32'h0040_0504, 32'h0040_0508, 32'h0, 0, 5));
    step("wait3_reset",  1, 0, 0, 32'h0,         0, 32'hBAD0_000F, ex(1, 32'h0040_0504, 32'h0040_0508, 32'h0, 0, 5));
    step("wait3_boot",   0, 0, 0, 32'h0,         1, 32'hBAD0_0010, ex(0, RST_PC,        32'h0040_0004, 32'h0, 0, 0));
    step("wait3_run",    0, 0, 0, 32'h0,         1, 32'hA000_0011, ex(1, 32'h0040_0000, 32'h0040_0004, 32'hA000_0011, 1, 0));
`else
    // Zero-wait build: a low ready input is ignored and fetch keeps streaming.
    step("noready_0",    0, 0, 0, 32'h0,         0, 32'hC000_0000, ex(1, 32'h0040_0004, 32'h0040_0008, 32'hC000_0000, 1, 1));
    step("noready_1",    0, 0, 0, 32'h0,         0, 32'hC000_0001, ex(1, 32'h0040_0008, 32'h0040_000C, 32'hC000_0001, 1, 2));
    step("noready_rdr",  0, 0, 1, 32'h0040_0700, 0, 32'hC000_0002, ex(1, 32'h0040_000C, 32'h0040_0010, 32'h0, 0, 3));
    step("noready_tgt",  0, 0, 0, 32'h0,         0, 32'hC000_0003, ex(1, 32'h0040_0700, 32'h0040_0704, 32'hC000_0003, 1, 3));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
